id_hazard_ctrl: RTL

Pipeline controller for the decode stages. It tracks in-flight loads in a small scoreboard and detects load-use hazards against the register addresses that decode delivers to ID1. It sequences stalls, bubble insertion into EX and flushes on EX redirects, and drives the hold/kill controls of the IF/ID0/ID1 pipeline registers.

---
 rtl/id_hazard_ctrl.sv | 172 +++++++++++++++++
 1 files changed

// File: rtl/id_hazard_ctrl.sv
// Decode-stage hazard controller: load-use scoreboard, stall/bubble sequencing and EX-redirect flush.
// Optional performance counters are built when HAZARD_PERF_CNT_EN is defined.
module id_hazard_ctrl #(
  parameter int LOAD_LAT     = 2,
  parameter int FLUSH_CYCLES = 2
) (
  input  logic        clk,
  input  logic        rst,
  input  logic        id_valid,
  input  logic [4:0]  id_rs1_addr,
  input  logic [4:0]  id_rs2_addr,
  input  logic        id_rs1_used,
  input  logic        id_rs2_used,
  input  logic [4:0]  id_rd_addr,
  input  logic        id_rd_wen,
  input  logic        id_is_load,
  input  logic        ex_busy,
  input  logic        ex_redirect,
  output logic        stall_if,
  output logic        stall_id,
  output logic        bubble_ex,
  output logic        flush,
  output logic        issue,
  output logic [31:0] perf_stall_cnt,
  output logic [31:0] perf_flush_cnt
);

  localparam int RegAddrWidth = 5;
  localparam logic [1:0] FlushReload = 2'((FLUSH_CYCLES > 1) ? (FLUSH_CYCLES - 2) : 0);

  if (LOAD_LAT < 1 || LOAD_LAT > 4) begin : g_bad_load_lat
    $error("LOAD_LAT must be in 1..4");
  end
  if (FLUSH_CYCLES < 1 || FLUSH_CYCLES > 4) begin : g_bad_flush_cycles
    $error("FLUSH_CYCLES must be in 1..4");
  end

  typedef enum logic {
    RUN   = 1'b0,
    FLUSH = 1'b1
  } state_t;

  state_t                  r_state;
  state_t                  w_state_nxt;
  logic [1:0]              r_flush_cnt;
  logic [1:0]              w_flush_cnt_nxt;

  logic                    r_sb_valid [LOAD_LAT];
  logic [RegAddrWidth-1:0] r_sb_rd    [LOAD_LAT];

  logic                    w_hazard;
  logic                    w_load_push;

  // Only entries that are still short of LOAD_LAT-1 cycles old can cause a stall;
  // the oldest entry is forwardable and needs no check.
  always_comb begin
    w_hazard = 1'b0;
    for (int i = 0; i < LOAD_LAT - 1; i++) begin
      if (r_sb_valid[i] &&
          ((id_rs1_used && (id_rs1_addr != '0) && (id_rs1_addr == r_sb_rd[i])) ||
           (id_rs2_used && (id_rs2_addr != '0) && (id_rs2_addr == r_sb_rd[i])))) begin
        w_hazard = 1'b1;
      end
    end
    w_hazard = w_hazard & id_valid;
  end

  // NOTE: every output gets a default first so no path through the priority chain infers a latch.
  always_comb begin
    stall_if  = 1'b0;
    stall_id  = 1'b0;
    bubble_ex = 1'b0;
    flush     = 1'b0;
    issue     = 1'b0;
    if (rst) begin
      // all controls low while in reset
    end else if (ex_redirect || (r_state == FLUSH)) begin
      flush = 1'b1;
    end else if (ex_busy) begin
      stall_if = 1'b1;
      stall_id = 1'b1;
    end else if (w_hazard) begin
      stall_if  = 1'b1;
      stall_id  = 1'b1;
      bubble_ex = 1'b1;
    end else begin
      issue = id_valid;
    end
  end

  assign w_load_push = issue & id_is_load & id_rd_wen & (id_rd_addr != '0);

  always_comb begin
    w_state_nxt     = r_state;
    w_flush_cnt_nxt = r_flush_cnt;
    case (r_state)
      RUN: begin
        if (ex_redirect && (FLUSH_CYCLES > 1)) begin
          w_state_nxt     = FLUSH;
          w_flush_cnt_nxt = FlushReload;
        end
      end
      FLUSH: begin
        if (ex_redirect) begin
          w_flush_cnt_nxt = FlushReload;
        end else if (r_flush_cnt == 2'd0) begin
          w_state_nxt = RUN;
        end else begin
          w_flush_cnt_nxt = r_flush_cnt - 2'd1;
        end
      end
      default: begin
        w_state_nxt     = RUN;
        w_flush_cnt_nxt = 2'd0;
      end
    endcase
  end

  // NOTE: sequential state uses non-blocking assignments so every flop samples pre-edge values.
  always_ff @(posedge clk) begin
    if (rst) begin
      r_state     <= RUN;
      r_flush_cnt <= 2'd0;
    end else begin
      r_state     <= w_state_nxt;
      r_flush_cnt <= w_flush_cnt_nxt;
    end
  end

  // NOTE: the scoreboard is reset explicitly; a stale valid bit after reset would stall forever-wrong.
  always_ff @(posedge clk) begin
    if (rst) begin
      for (int i = 0; i < LOAD_LAT; i++) begin
        r_sb_valid[i] <= 1'b0;
        r_sb_rd[i]    <= '0;
      end
    end else if (!ex_busy) begin
      for (int i = LOAD_LAT - 1; i > 0; i--) begin
        r_sb_valid[i] <= r_sb_valid[i-1];
        r_sb_rd[i]    <= r_sb_rd[i-1];
      end
      r_sb_valid[0] <= w_load_push;
      r_sb_rd[0]    <= w_load_push ? id_rd_addr : '0;
    end
  end

`ifdef HAZARD_PERF_CNT_EN
  logic [31:0] r_perf_stall_cnt;
  logic [31:0] r_perf_flush_cnt;

  always_ff @(posedge clk) begin
    if (rst) begin
      r_perf_stall_cnt <= '0;
      r_perf_flush_cnt <= '0;
    end else begin
      if (stall_id && (r_perf_stall_cnt != '1)) begin
        r_perf_stall_cnt <= r_perf_stall_cnt + 32'd1;
      end
      if (ex_redirect && (r_perf_flush_cnt != '1)) begin
        r_perf_flush_cnt <= r_perf_flush_cnt + 32'd1;
      end
    end
  end

  assign perf_stall_cnt = r_perf_stall_cnt;
  assign perf_flush_cnt = r_perf_flush_cnt;
`else
  assign perf_stall_cnt = '0;
  assign perf_flush_cnt = '0;
`endif

endmodule
